ramp_adc_sequencer: RTL



---
 rtl/ramp_adc_pkg.sv | 55 +++++
 rtl/sync_pipe.sv | 21 ++
 rtl/ramp_adc_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/ramp_adc_pkg.sv
// Shared types and helpers for the ramp ADC sequencer: FSM states, per-phase
// switch/busy drive pattern and the round-robin channel picker.
package ramp_adc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_DISCHARGE,
    S_GAP1,
    S_RAMP_UP,
    S_GAP2,
    S_RAMP_DOWN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic cap;
    logic up;
    logic down;
    logic busy;
  } drive_t;

  // At most one switch is ever set; the gap states open every switch.
  function automatic drive_t phase_drive(input state_t s);
    drive_t d;
    d = '0;
    case (s)
      S_IDLE:                 d.cap = 1'b1;
      S_SETTLE, S_DISCHARGE:  begin d.cap = 1'b1; d.busy = 1'b1; end
      S_GAP1, S_GAP2:         d.busy = 1'b1;
      S_RAMP_UP:              begin d.up = 1'b1; d.busy = 1'b1; end
      S_RAMP_DOWN:            begin d.down = 1'b1; d.busy = 1'b1; end
      S_DONE:                 begin d.cap = 1'b1; d.busy = 1'b1; end
      default:                d.cap = 1'b1;
    endcase
    return d;
  endfunction

  // Lowest enabled channel strictly above 'last', wrapping modulo nch (1..8).
  function automatic logic [2:0] next_channel(input logic [7:0] mask,
                                              input logic [2:0] last,
                                              input int         nch);
    logic [2:0] pick;
    int         idx;
    pick = last;
    for (int i = 8; i >= 1; i--) begin
      if (i <= nch) begin
        idx = (int'(last) + i) % nch;
        if (mask[3'(idx)]) pick = 3'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sync_pipe.sv
// Single-bit multi-flop synchronizer; resets to 1 so an idle comparator
// reads as "cap above threshold".
module sync_pipe #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk) begin
    if (reset) sync_p <= '1;
    else       sync_p <= {sync_p[STAGES-2:0], d};
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/ramp_adc_sequencer.sv
// Dual-slope ramp ADC sequencer: walks each enabled channel through settle,
// discharge, integrate and de-integrate, timing the de-integrate phase.
module ramp_adc_sequencer
  import ramp_adc_pkg::*;
#(
  parameter int NCH           = 4,
  parameter int TW            = 20,
  parameter int SETTLE_CYCLES = 650,
  parameter int RESET_CYCLES  = 65000,
  parameter int UP_CYCLES     = 650000,
  parameter int SYNC_STAGES   = 2,
  localparam int CW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           continuous,
  input  logic           start,
  input  logic [NCH-1:0] ch_mask,
  input  logic           comparator,
  output logic           reset_cap_sw,
  output logic           ramp_up_sw,
  output logic           ramp_down_sw,
  output logic [CW-1:0]  ch_sel,
  output logic           busy,
  output logic [TW-1:0]  down_ramp_time,
  output logic [CW-1:0]  ch_id,
  output logic           overflow,
  output logic           eoc
);

  localparam int CNT_A = (TW > $clog2(RESET_CYCLES + 1)) ? TW : $clog2(RESET_CYCLES + 1);
  localparam int CNT_W = (CNT_A > $clog2(SETTLE_CYCLES + 1)) ? CNT_A : $clog2(SETTLE_CYCLES + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] UP_LAST     = CNT_W'(UP_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_DOWN_C  = CNT_W'((2 ** TW) - 1);
  localparam logic [CNT_W-1:0] SYNC_C      = CNT_W'(SYNC_STAGES);
  localparam logic [TW-1:0]    MAX_DOWN_R  = '1;
  localparam logic [CW-1:0]    LAST_RST    = CW'(NCH - 1);

  state_t           state;
  drive_t           drv;
  logic [CNT_W-1:0] cnt;
  logic [CW-1:0]    last_ptr;
  logic             comp_sync;
  logic [7:0]       mask8;
  logic [2:0]       pick3;
  logic [TW-1:0]    rd_n;

  sync_pipe #(.STAGES(SYNC_STAGES)) u_comp_sync (
    .clk   (clk),
    .reset (reset),
    .d     (comparator),
    .q     (comp_sync)
  );

  always_comb begin
    mask8          = '0;
    mask8[NCH-1:0] = ch_mask;
  end

  assign pick3 = next_channel(mask8, 3'(last_ptr), NCH);

  // Synchronizer latency is removed so the result is the raw crossing index.
  assign rd_n = (cnt >= SYNC_C) ? TW'(cnt - SYNC_C) : '0;

  assign reset_cap_sw = drv.cap;
  assign ramp_up_sw   = drv.up;
  assign ramp_down_sw = drv.down;
  assign busy         = drv.busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      drv            <= phase_drive(S_IDLE);
      cnt            <= '0;
      last_ptr       <= LAST_RST;
      ch_sel         <= '0;
      down_ramp_time <= '0;
      ch_id          <= '0;
      overflow       <= 1'b0;
      eoc            <= 1'b0;
    end else begin
      eoc <= 1'b0;
      if (!enable && state != S_IDLE) begin
        state <= S_IDLE;
        drv   <= phase_drive(S_IDLE);
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (enable && (|ch_mask) && (continuous || start)) begin
              ch_sel <= pick3[CW-1:0];
              cnt    <= '0;
              state  <= S_SETTLE;
              drv    <= phase_drive(S_SETTLE);
            end
          end
          S_SETTLE: begin
            if (cnt == SETTLE_LAST) begin
              cnt   <= '0;
              state <= S_DISCHARGE;
              drv   <= phase_drive(S_DISCHARGE);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_DISCHARGE: begin
            if (cnt == RESET_LAST) begin
              cnt   <= '0;
              state <= S_GAP1;
              drv   <= phase_drive(S_GAP1);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_GAP1: begin
            state <= S_RAMP_UP;
            drv   <= phase_drive(S_RAMP_UP);
          end
          S_RAMP_UP: begin
            if (cnt == UP_LAST) begin
              cnt   <= '0;
              state <= S_GAP2;
              drv   <= phase_drive(S_GAP2);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_GAP2: begin
            state <= S_RAMP_DOWN;
            drv   <= phase_drive(S_RAMP_DOWN);
          end
          S_RAMP_DOWN: begin
            if (!comp_sync || cnt == MAX_DOWN_C) begin
              down_ramp_time <= comp_sync ? MAX_DOWN_R : rd_n;
              overflow       <= comp_sync;
              ch_id          <= ch_sel;
              last_ptr       <= ch_sel;
              eoc            <= 1'b1;
              state          <= S_DONE;
              drv            <= phase_drive(S_DONE);
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            drv   <= phase_drive(S_IDLE);
          end
          default: begin
            state <= S_IDLE;
            drv   <= phase_drive(S_IDLE);
          end
        endcase
      end
    end
  end

endmodule
